// File: rtl/cpu_0_ocimem_monitor.sv
// Debug RAM shared between the CPU debug slave port and the JTAG monitor engine.
// The monitor FSM runs the jdo commands; the CPU is stalled only while the monitor owns the RAM.
module cpu_0_ocimem_monitor #(
  parameter int RAM_AW = 8,
  parameter int RAM_DW = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [RAM_AW-1:0] address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [RAM_DW-1:0] writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [RAM_DW-1:0] readdata,
  output logic              waitrequest,
  output logic [RAM_DW-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [1:0]        mon_state,
  output logic [RAM_AW-1:0] mon_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MWR  = 2'd1,
    MRD  = 2'd2,
    MCAP = 2'd3
  } mon_state_e;

  mon_state_e        state_q;
  mon_state_e        state_d;
  logic [RAM_AW-1:0] mon_a_reg;
  logic [RAM_DW-1:0] mon_wdata;
  logic [RAM_DW-1:0] ram [0:(1<<RAM_AW)-1];
  logic [RAM_DW-1:0] ram_q;
  logic [RAM_DW-1:0] rd_hold;
  logic              cpu_rd_d;

  logic acc_a;
  logic acc_b;
  logic acc_rd;
  logic drop;
  logic any_strobe;
  logic mon_owns;
  logic cpu_rd;
  logic cpu_wr;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[33]};
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // CPU slave handshake: chipselect offers an access, which is accepted in any
  // cycle waitrequest is low; an accepted read returns readdata the next cycle.
  assign mon_owns    = (state_q == MWR) || (state_q == MRD);
  assign waitrequest = chipselect & mon_owns;
  assign cpu_rd      = chipselect & ~write & ~mon_owns;
  assign cpu_wr      = chipselect & write & ~mon_owns & debugaccess;

  assign mon_state = state_q;
  assign mon_addr  = mon_a_reg;

  always_comb begin
    state_d = state_q;
    acc_a   = 1'b0;
    acc_b   = 1'b0;
    acc_rd  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          acc_a = 1'b1;
          drop  = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[35]) state_d = MRD;
        end else if (take_action_ocimem_b) begin
          acc_b   = 1'b1;
          drop    = take_no_action_ocimem_a;
          state_d = MWR;
        end else if (take_no_action_ocimem_a) begin
          acc_rd  = 1'b1;
          state_d = MRD;
        end
      end
      MWR: begin
        drop    = any_strobe;
        state_d = IDLE;
      end
      MRD: begin
        drop    = any_strobe;
        state_d = MCAP;
      end
      MCAP: begin
        drop    = any_strobe;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single RAM port: the monitor has it in MWR/MRD, the CPU in every other cycle.
  always_ff @(posedge clk) begin
    if (state_q == MWR) begin
      ram[mon_a_reg] <= mon_wdata;
    end else if (cpu_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) ram[address][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
    if (state_q == MRD) begin
      ram_q <= ram[mon_a_reg];
    end else if (cpu_rd) begin
      ram_q <= ram[address];
    end
  end

  // ram_q is shared, so a CPU result is parked in rd_hold before a monitor read reuses it.
  assign readdata = cpu_rd_d ? ram_q : rd_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mon_a_reg     <= '0;
      mon_wdata     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      rd_hold       <= '0;
      cpu_rd_d      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_rd_d <= cpu_rd;
      if (cpu_rd_d) rd_hold <= ram_q;

      if (acc_a) begin
        mon_a_reg <= jdo[25 +: RAM_AW];
        if (jdo[34]) begin
          monitor_ready <= 1'b0;
          monitor_error <= 1'b0;
        end
        if (jdo[35]) monitor_ready <= 1'b0;
      end
      if (acc_b) begin
        mon_wdata     <= jdo[RAM_DW-1:0];
        monitor_ready <= 1'b0;
      end
      if (acc_rd) monitor_ready <= 1'b0;

      if ((state_q == MWR) || (state_q == MCAP)) begin
        mon_a_reg     <= mon_a_reg + RAM_AW'(1);
        monitor_ready <= 1'b1;
      end
      if (state_q == MCAP) MonDReg <= ram_q;

      // A dropped strobe wins over a clear arriving in the same cycle.
      if (drop) monitor_error <= 1'b1;
    end
  end

endmodule
